// File: rtl/line_pixel_sink.sv
// line_pixel_sink
//   Consumer end of the line generator. Buffers incoming (x,y) pixels in a
//   small FIFO, turns each into a linear framebuffer address y*H_RES+x and
//   issues colour writes under framebuffer backpressure. Raises finish once
//   a line has been fully written out.
//
//   Optional build macro FB_BOUNDS_CHECK_EN: when defined, pixels outside
//   H_RES x V_RES are discarded in stage A and counted in drop_count. When
//   undefined, addresses are written truncated to ADDR_W bits and
//   drop_count is tied to 0.
//
// Ports
//   clk, rst_n          clock, synchronous active-low reset
//   start, color        begin a line / line colour (sampled on start)
//   pix_valid/ready     pixel stream handshake, pix_x/pix_y coordinates
//   line_done           generator finished (level or pulse)
//   fb_we/addr/data     framebuffer write request, fb_wready accepts it
//   busy, finish        RUN|DRAIN / line fully written (held until start)
//   pix_count           writes completed this line (saturating)
//   drop_count          pixels discarded this line (saturating)
module line_pixel_sink #(
    parameter int H_RES   = 640,
    parameter int V_RES   = 480,
    parameter int ADDR_W  = 19,
    parameter int COLOR_W = 8,
    parameter int DEPTH   = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [COLOR_W-1:0] color,
    input  logic               pix_valid,
    output logic               pix_ready,
    input  logic [9:0]         pix_x,
    input  logic [8:0]         pix_y,
    input  logic               line_done,
    output logic               fb_we,
    output logic [ADDR_W-1:0]  fb_addr,
    output logic [COLOR_W-1:0] fb_data,
    input  logic               fb_wready,
    output logic               busy,
    output logic               finish,
    output logic [19:0]        pix_count,
    output logic [19:0]        drop_count
);

    localparam int PW = $clog2(DEPTH);

    // The whole visible frame must be addressable.
    if (H_RES * V_RES > (1 << ADDR_W)) begin : g_addr_too_narrow
        $error("ADDR_W too narrow for H_RES*V_RES");
    end

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t              state_q, state_d;
    logic [COLOR_W-1:0]  color_q;

    logic [9:0]          mem_x [DEPTH];
    logic [8:0]          mem_y [DEPTH];
    logic [PW-1:0]       wr_ptr, rd_ptr;
    logic [PW:0]         occ;

    logic                a_vld;
    logic [9:0]          a_x;
    logic [8:0]          a_y;
    logic                a_inb;

    logic                push, pop, full, b_stall, a_adv, wr_done;
    logic [ADDR_W-1:0]   a_addr;

    assign full    = (occ == (PW+1)'(DEPTH));
    assign push    = pix_valid && pix_ready;
    assign wr_done = fb_we && fb_wready;
    // Stage B is frozen while a write waits; stage A may only refill when
    // it is empty or its contents can move into B.
    assign b_stall = fb_we && !fb_wready;
    assign a_adv   = !a_vld || !b_stall;
    assign pop     = (occ != '0) && a_adv;
    assign a_addr  = ADDR_W'(a_y) * ADDR_W'(H_RES) + ADDR_W'(a_x);

`ifdef FB_BOUNDS_CHECK_EN
    assign a_inb = (int'(a_x) < H_RES) && (int'(a_y) < V_RES);
`else
    assign a_inb = 1'b1;
`endif

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        pix_ready = 1'b0;
        busy      = 1'b0;
        finish    = 1'b0;
        case (state_q)
            IDLE:  ;
            RUN: begin
                pix_ready = !full;
                busy      = 1'b1;
                if (line_done) state_d = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                if (occ == '0 && !a_vld && !fb_we) state_d = DONE;
            end
            DONE:  finish = 1'b1;
            default: state_d = IDLE;
        endcase
        if (start) state_d = RUN;
    end

    // ---------------- FIFO storage (no reset needed, pointers qualify it) --
    always_ff @(posedge clk) begin
        if (push) begin
            mem_x[wr_ptr] <= pix_x;
            mem_y[wr_ptr] <= pix_y;
        end
    end

    // ---------------- FIFO control + pipeline ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occ       <= '0;
            a_vld     <= 1'b0;
            a_x       <= '0;
            a_y       <= '0;
            fb_we     <= 1'b0;
            fb_addr   <= '0;
            fb_data   <= '0;
            color_q   <= '0;
            pix_count <= '0;
        end else if (start) begin
            // Flush everything in flight; a pixel offered this cycle is lost.
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occ       <= '0;
            a_vld     <= 1'b0;
            fb_we     <= 1'b0;
            color_q   <= color;
            pix_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: ;
            endcase

            if (a_adv) begin
                a_vld <= pop;
                if (pop) begin
                    a_x <= mem_x[rd_ptr];
                    a_y <= mem_y[rd_ptr];
                end
            end

            if (!b_stall) begin
                fb_we <= a_vld && a_inb;
                if (a_vld && a_inb) begin
                    fb_addr <= a_addr;
                    fb_data <= color_q;
                end
            end

            if (wr_done && pix_count != '1) pix_count <= pix_count + 1'b1;
        end
    end

`ifdef FB_BOUNDS_CHECK_EN
    // A discarded pixel leaves stage A whenever B would have taken it.
    always_ff @(posedge clk) begin
        if (!rst_n || start)
            drop_count <= '0;
        else if (a_vld && !a_inb && !b_stall && drop_count != '1)
            drop_count <= drop_count + 1'b1;
    end
`else
    assign drop_count = '0;
`endif

endmodule

// File: tb/tb_line_pixel_sink.sv
module tb_line_pixel_sink;

    localparam int H = 640, V = 480, AW = 19, CW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0, start = 1'b0, pix_valid = 1'b0, line_done = 1'b0;
    logic          fb_wready = 1'b1;
    logic [CW-1:0] color = '0;
    logic [9:0]    pix_x = '0;
    logic [8:0]    pix_y = '0;
    logic          pix_ready, fb_we, busy, finish;
    logic [AW-1:0] fb_addr;
    logic [CW-1:0] fb_data;
    logic [19:0]   pix_count, drop_count;

    line_pixel_sink #(.H_RES(H), .V_RES(V), .ADDR_W(AW), .COLOR_W(CW), .DEPTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .color(color),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_x(pix_x), .pix_y(pix_y),
        .line_done(line_done), .fb_we(fb_we), .fb_addr(fb_addr), .fb_data(fb_data),
        .fb_wready(fb_wready), .busy(busy), .finish(finish),
        .pix_count(pix_count), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // fb_wready driver: fixed level or 50% random.
    bit wr_rand = 1'b0, wr_fixed = 1'b1;
    always @(posedge clk) begin
        #1;
        fb_wready = wr_rand ? 1'($urandom_range(0, 1)) : wr_fixed;
    end

    // Reference model: the framebuffer must see exactly the accepted,
    // in-range pixels, in order, each at y*H+x modulo 2^AW, in line colour.
    int        q[$];
    int        m_pix = 0, m_drop = 0, n_wr = 0, first_wr = 0, last_wr = 0;
    logic [CW-1:0] m_color = '0;

    function automatic bit in_range(int x, int y);
`ifdef FB_BOUNDS_CHECK_EN
        return x < H && y < V;
`else
        return 1'b1;
`endif
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete(); m_pix = 0; m_drop = 0; n_wr = 0;
        end else begin
            if (fb_we && fb_wready) begin
                chk("wr_expected", 32'(q.size() != 0), 1);
                if (q.size() != 0) begin
                    chk("wr_addr", fb_addr, q.pop_front());
                    chk("wr_data", fb_data, m_color);
                end
                n_wr++;
                if (n_wr == 1) first_wr = fb_addr;
                last_wr = fb_addr;
            end
            if (start) begin
                q.delete(); m_pix = 0; m_drop = 0; n_wr = 0; m_color = color;
            end else if (pix_valid && pix_ready) begin
                if (in_range(pix_x, pix_y)) begin
                    q.push_back((int'(pix_y) * H + int'(pix_x)) % (1 << AW));
                    m_pix++;
                end else m_drop++;
            end
        end
    end

    int sx[$], sy[$];

    // All driver tasks begin and end 1 time unit after a rising edge.
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic pulse_start(input logic [CW-1:0] c);
        start = 1'b1; color = c;
        tick();
        start = 1'b0;
    endtask

    task automatic stream(input int max_cyc, output int acc, output int stalls);
        int i = 0;
        bit ok;
        acc = 0; stalls = 0;
        for (int c = 0; c < max_cyc && i < sx.size(); c++) begin
            pix_valid = 1'b1; pix_x = 10'(sx[i]); pix_y = 9'(sy[i]);
            @(negedge clk); ok = pix_ready;
            tick();
            if (ok) begin i++; acc++; end else stalls++;
        end
        pix_valid = 1'b0;
    endtask

    task automatic end_line(input string tag);
        int c = 0;
        line_done = 1'b1;
        tick();
        line_done = 1'b0;
        while (!finish && c < 400) begin tick(); c++; end
        chk({tag, "_finish"}, finish, 1);
        chk({tag, "_pix_count"}, pix_count, m_pix);
        chk({tag, "_drop_count"}, drop_count, m_drop);
        chk({tag, "_drained"}, q.size(), 0);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_pix_ready"}, pix_ready, 0);
        chk({tag, "_fb_we"}, fb_we, 0);
        chk({tag, "_fb_addr"}, fb_addr, 0);
        chk({tag, "_fb_data"}, fb_data, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_finish"}, finish, 0);
        chk({tag, "_pix_count"}, pix_count, 0);
        chk({tag, "_drop_count"}, drop_count, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, st, a0;

        // Reset
        rst_n = 1'b0; tick(); tick();
        chk_reset("reset");
        rst_n = 1'b1; tick();

        // Single pixel with latency check
        pulse_start(8'h5A);
        pix_valid = 1'b1; pix_x = 10; pix_y = 20;
        tick();                                    // edge N accepts
        pix_valid = 1'b0;
        chk("lat_n", fb_we, 0);
        tick();
        chk("lat_n1", fb_we, 0);
        tick();
        chk("lat_n2_we", fb_we, 1);
        chk("lat_n2_addr", fb_addr, 12810);
        chk("lat_n2_data", fb_data, 8'h5A);
        end_line("single");

        // Diagonal line, back-to-back
        sx.delete(); sy.delete();
        for (int i = 0; i <= 20; i++) begin sx.push_back(10 + i); sy.push_back(20 + i); end
        pulse_start(8'hC3);
        stream(100, acc, st);
        chk("diag_acc", acc, 21);
        chk("diag_stalls", st, 0);
        end_line("diag");
        chk("diag_first", first_wr, 12810);
        chk("diag_last", last_wr, 25630);
        chk("diag_nwr", n_wr, 21);

        // Backpressure: storage is FIFO depth + 2 stages
        wr_fixed = 1'b0;
        sx.delete(); sy.delete();
        for (int i = 0; i < 20; i++) begin sx.push_back(100 + i); sy.push_back(7); end
        pulse_start(8'h11);
        stream(30, acc, st);
        chk("bp_acc", acc, 10);
        chk("bp_ready", pix_ready, 0);
        a0 = fb_addr;
        chk("bp_addr", a0, 7 * H + 100);
        repeat (3) tick();
        chk("bp_stable", fb_addr, a0);
        wr_fixed = 1'b1;
        end_line("bp");
        chk("bp_nwr", n_wr, 10);

        // Random backpressure, 100 random pixels
        wr_rand = 1'b1;
        sx.delete(); sy.delete();
        for (int i = 0; i < 100; i++) begin
            sx.push_back($urandom_range(0, H - 1)); sy.push_back($urandom_range(0, V - 1));
        end
        pulse_start(8'($urandom));
        stream(2000, acc, st);
        chk("rnd_acc", acc, 100);
        end_line("rnd");
        chk("rnd_pix", pix_count, 100);
        wr_rand = 1'b0;
        tick();

        // Out-of-range pixels
        sx.delete(); sy.delete();
`ifdef FB_BOUNDS_CHECK_EN
        sx = '{640, 3, 1}; sy = '{5, 480, 1};
        pulse_start(8'h77);
        stream(50, acc, st);
        end_line("oob");
        chk("oob_drop", drop_count, 2);
        chk("oob_pix", pix_count, 1);
        chk("oob_addr", last_wr, 641);
`else
        sx = '{640}; sy = '{5};
        pulse_start(8'h77);
        stream(50, acc, st);
        end_line("oob");
        chk("oob_addr", last_wr, 3840);
        chk("oob_drop", drop_count, 0);
`endif

        // start during DRAIN with pixels still buffered
        wr_fixed = 1'b0;
        tick();
        sx.delete(); sy.delete();
        for (int i = 0; i < 7; i++) begin sx.push_back(i); sy.push_back(3); end
        pulse_start(8'h22);
        stream(30, acc, st);
        chk("dr_acc", acc, 7);
        line_done = 1'b1; tick(); line_done = 1'b0;
        chk("dr_busy", busy, 1);
        chk("dr_finish", finish, 0);
        pulse_start(8'h33);
        chk("dr_we_dropped", fb_we, 0);
        chk("dr_pix_count", pix_count, 0);
        chk("dr_run", pix_ready, 1);
        wr_fixed = 1'b1;
        repeat (6) tick();
        chk("dr_no_stale", n_wr, 0);
        sx.delete(); sy.delete();
        sx = '{50, 51}; sy = '{60, 61};
        stream(20, acc, st);
        end_line("dr_after");

        // Reset in the middle of a line
        sx.delete(); sy.delete();
        for (int i = 0; i < 6; i++) begin sx.push_back(200 + i); sy.push_back(100); end
        pulse_start(8'h44);
        stream(20, acc, st);
        chk("mid_busy", busy, 1);
        rst_n = 1'b0; tick();
        chk_reset("midrst");
        rst_n = 1'b1; tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
